// File: rtl/spi_sender_shift_unit_if.sv
// Sender-side bus between the SPI control block and the transmit shift unit.
// master = control/buffer side, slave = shift unit.
interface spi_sender_shift_unit_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  SENDER_WRITE;
    logic [DATA_WIDTH-1:0] BUFFER_DATA;
    logic                  TE;
    logic                  CS;
    logic                  OVR_CLR;
    logic                  SCLK;
    logic                  MOSI;
    logic                  SENDER_FULL_STATE;
    logic                  SENDER_EMPTY_STATE;
    logic                  TX_DONE;
    logic                  OVERRUN;

    modport master (
        output SENDER_WRITE, BUFFER_DATA, TE, CS, OVR_CLR,
        input  SCLK, MOSI, SENDER_FULL_STATE, SENDER_EMPTY_STATE, TX_DONE, OVERRUN
    );

    modport slave (
        input  SENDER_WRITE, BUFFER_DATA, TE, CS, OVR_CLR,
        output SCLK, MOSI, SENDER_FULL_STATE, SENDER_EMPTY_STATE, TX_DONE, OVERRUN
    );
endinterface

// File: rtl/spi_sender_shift_unit.sv
// SPI mode-0 transmit shifter with one-word holding register; SETUP to TX_DONE = 1 + 2*CLK_DIV*DATA_WIDTH cycles.
// No backpressure: a write while the holding register is full and not being consumed is dropped and flags OVERRUN.
module spi_sender_shift_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input logic                    CLK,
    input logic                    CLR,
    spi_sender_shift_unit_if.slave bus
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic [DATA_WIDTH-1:0] shift_dat;
    logic                  full;
    logic                  sclk;
    logic                  mosi;
    logic                  overrun;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  go;
    logic                  abort;
    logic                  div_end;
    logic                  consume;
    logic                  wr_accept;
    logic                  wr_reject;
    logic                  next_bit;

    assign go        = full && bus.TE && !bus.CS;
    assign abort     = !bus.TE || bus.CS;
    assign div_end   = (div_cnt == DIV_LAST);
    assign consume   = (state_nxt == SETUP);
    assign wr_accept = bus.SENDER_WRITE && (!full || consume);
    assign wr_reject = bus.SENDER_WRITE && full && !consume;
    assign next_bit  = MSB_FIRST ? shift_dat[DATA_WIDTH-2] : shift_dat[1];

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (go) state_nxt = SETUP;
            SETUP:    state_nxt = abort ? IDLE : SHIFT_LO;
            SHIFT_LO: begin
                if (abort)        state_nxt = IDLE;
                else if (div_end) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (abort)        state_nxt = IDLE;
                else if (div_end) state_nxt = (bit_cnt == '0) ? DONE : SHIFT_LO;
            end
            DONE:     state_nxt = go ? SETUP : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The holding register is consumed on the edge that enters SETUP, so a write
    // on that same edge refills it instead of being counted as an overrun.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            hold_dat  <= '0;
            shift_dat <= '0;
            full      <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            overrun   <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            sclk <= (state_nxt == SHIFT_HI);

            if (wr_accept)    hold_dat <= bus.BUFFER_DATA;
            if (wr_accept)    full <= 1'b1;
            else if (consume) full <= 1'b0;

            if (wr_reject)        overrun <= 1'b1;
            else if (bus.OVR_CLR) overrun <= 1'b0;

            // Half-period counter restarts on every phase change.
            if ((state_nxt == SHIFT_LO || state_nxt == SHIFT_HI) && state_nxt == state)
                div_cnt <= div_cnt + 1'b1;
            else
                div_cnt <= '0;

            if (consume) begin
                shift_dat <= hold_dat;
                mosi      <= MSB_FIRST ? hold_dat[DATA_WIDTH-1] : hold_dat[0];
                bit_cnt   <= BIT_LAST;
            end else if (state == SHIFT_HI && state_nxt == SHIFT_LO) begin
                shift_dat <= MSB_FIRST ? (shift_dat << 1) : (shift_dat >> 1);
                mosi      <= next_bit;
                bit_cnt   <= bit_cnt - 1'b1;
            end else if (state_nxt == IDLE) begin
                mosi      <= 1'b0;
            end
        end
    end

    assign bus.SCLK               = sclk;
    assign bus.MOSI               = mosi;
    assign bus.SENDER_FULL_STATE  = full;
    assign bus.SENDER_EMPTY_STATE = !full && (state == IDLE);
    assign bus.TX_DONE            = (state == DONE);
    assign bus.OVERRUN            = overrun;
endmodule

// File: tb/tb_spi_sender_shift_unit.sv
// Bench for spi_sender_shift_unit: two instances (MSB-first and LSB-first, CLK_DIV=2) share one
// stimulus stream and are compared every cycle against a transfer-timeline model.
module tb_spi_sender_shift_unit;
    localparam int W    = 8;
    localparam int D    = 2;
    localparam int LAST = 1 + 2 * D * W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_sender_shift_unit_if #(.DATA_WIDTH(W)) ifa ();
    spi_sender_shift_unit_if #(.DATA_WIDTH(W)) ifb ();

    assign ifb.SENDER_WRITE = ifa.SENDER_WRITE;
    assign ifb.BUFFER_DATA  = ifa.BUFFER_DATA;
    assign ifb.TE           = ifa.TE;
    assign ifb.CS           = ifa.CS;
    assign ifb.OVR_CLR      = ifa.OVR_CLR;

    spi_sender_shift_unit #(.DATA_WIDTH(W), .CLK_DIV(D), .MSB_FIRST(1'b1)) dut_a (
        .CLK(clk), .CLR(rst_n), .bus(ifa));
    spi_sender_shift_unit #(.DATA_WIDTH(W), .CLK_DIV(D), .MSB_FIRST(1'b0)) dut_b (
        .CLK(clk), .CLR(rst_n), .bus(ifb));

    // Model: a transfer is a timeline t = 0 (setup) .. LAST (done) from the cycle it starts.
    typedef struct packed {
        logic         active;
        int           t;
        logic         full;
        logic [W-1:0] hold;
        logic [W-1:0] word;
        logic         ovr;
    } mdl_t;

    mdl_t m;
    int   errors = 0;
    int   checks = 0;

    function automatic mdl_t step(mdl_t c, logic wr, logic [W-1:0] d, logic te, logic cs, logic oc);
        mdl_t n;
        logic start;
        logic abort;
        n     = c;
        start = (!c.active || c.t == LAST) && c.full && te && !cs;
        abort = c.active && c.t != LAST && (!te || cs);
        if (start) begin
            n.active = 1'b1;
            n.t      = 0;
            n.word   = c.hold;
        end else if (abort) begin
            n.active = 1'b0;
        end else if (c.active) begin
            if (c.t == LAST) n.active = 1'b0;
            else             n.t = c.t + 1;
        end
        if (wr && (!c.full || start)) begin
            n.hold = d;
            n.full = 1'b1;
        end else if (start) begin
            n.full = 1'b0;
        end
        if (wr && c.full && !start) n.ovr = 1'b1;
        else if (oc)                n.ovr = 1'b0;
        return n;
    endfunction

    function automatic logic exp_sclk(mdl_t c);
        return c.active && c.t >= 1 && c.t < LAST && (((c.t - 1) / D) % 2 == 1);
    endfunction

    function automatic logic exp_mosi(mdl_t c, bit msb);
        int idx;
        if (!c.active) return 1'b0;
        if (c.t == 0)         idx = 0;
        else if (c.t == LAST) idx = W - 1;
        else                  idx = (c.t - 1) / (2 * D);
        return msb ? c.word[W-1-idx] : c.word[idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, ifa.SENDER_WRITE, ifa.BUFFER_DATA, ifa.TE, ifa.CS, ifa.OVR_CLR);
    end

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk1("a_sclk",  ifa.SCLK,               exp_sclk(m));
        chk1("a_mosi",  ifa.MOSI,               exp_mosi(m, 1'b1));
        chk1("a_full",  ifa.SENDER_FULL_STATE,  m.full);
        chk1("a_empty", ifa.SENDER_EMPTY_STATE, !m.full && !m.active);
        chk1("a_done",  ifa.TX_DONE,            m.active && m.t == LAST);
        chk1("a_ovr",   ifa.OVERRUN,            m.ovr);
        chk1("b_sclk",  ifb.SCLK,               exp_sclk(m));
        chk1("b_mosi",  ifb.MOSI,               exp_mosi(m, 1'b0));
        chk1("b_empty", ifb.SENDER_EMPTY_STATE, !m.full && !m.active);
        chk1("b_done",  ifb.TX_DONE,            m.active && m.t == LAST);
    end

    // Directed observation: counts cycles, SCLK rises and TX_DONE pulses.
    int          ncyc = 0, rises = 0, dones = 0, first_done = 0, last_done = 0;
    logic [15:0] rx_a = '0, rx_b = '0;
    logic        prev_sclk = 1'b0;

    task automatic cycle();
        @(negedge clk);
        ncyc++;
        if (ifa.SCLK && !prev_sclk) begin
            rises++;
            rx_a = {rx_a[14:0], ifa.MOSI};
            rx_b = {rx_b[14:0], ifb.MOSI};
        end
        prev_sclk = ifa.SCLK;
        if (ifa.TX_DONE) begin
            if (dones == 0) first_done = ncyc;
            last_done = ncyc;
            dones++;
        end
    endtask

    task automatic clear_obs();
        ncyc = 0; rises = 0; dones = 0; first_done = 0; last_done = 0;
        rx_a = '0; rx_b = '0;
    endtask

    task automatic write_word(logic [W-1:0] d);
        ifa.SENDER_WRITE = 1'b1;
        ifa.BUFFER_DATA  = d;
        cycle();
        ifa.SENDER_WRITE = 1'b0;
    endtask

    task automatic wait_done(int target, int budget);
        int n = 0;
        while (dones < target && n < budget) begin
            cycle();
            n++;
        end
        chk1("done_within_budget", dones >= target, 1'b1);
    endtask

    initial begin
        ifa.SENDER_WRITE = 1'b0;
        ifa.BUFFER_DATA  = '0;
        ifa.TE           = 1'b0;
        ifa.CS           = 1'b1;
        ifa.OVR_CLR      = 1'b0;
        cycle(); cycle();
        chk1("rst_sclk",  ifa.SCLK, 1'b0);
        chk1("rst_mosi",  ifa.MOSI, 1'b0);
        chk1("rst_full",  ifa.SENDER_FULL_STATE, 1'b0);
        chk1("rst_empty", ifa.SENDER_EMPTY_STATE, 1'b1);
        chk1("rst_done",  ifa.TX_DONE, 1'b0);
        chk1("rst_ovr",   ifa.OVERRUN, 1'b0);
        rst_n = 1'b1;
        cycle();

        // Single word: write edge, one IDLE cycle, then 33 cycles to TX_DONE.
        ifa.TE = 1'b1; ifa.CS = 1'b0;
        cycle();
        clear_obs();
        write_word(8'hA5);
        wait_done(1, 60);
        chkv("a5_latency", first_done, 35);
        chkv("a5_rises",   rises, 8);
        chkv("a5_msb",     32'(rx_a[7:0]), 32'hA5);
        chkv("a5_lsb",     32'(rx_b[7:0]), 32'hA5);
        cycle();
        chk1("a5_empty_after", ifa.SENDER_EMPTY_STATE, 1'b1);

        clear_obs();
        write_word(8'h01);
        wait_done(1, 60);
        chkv("x01_msb", 32'(rx_a[7:0]), 32'h01);
        chkv("x01_lsb", 32'(rx_b[7:0]), 32'h80);

        // Back-to-back: second word lands while the first is shifting.
        cycle();
        clear_obs();
        write_word(8'h3C);
        repeat (4) cycle();
        write_word(8'hC3);
        wait_done(2, 120);
        chkv("b2b_gap",   last_done - first_done, 34);
        chkv("b2b_rises", rises, 16);
        chkv("b2b_msb",   32'(rx_a), 32'h3CC3);
        chkv("b2b_lsb",   32'(rx_b), 32'h3CC3);

        // Overrun while transmit is disabled.
        repeat (2) cycle();
        ifa.TE = 1'b0;
        cycle();
        write_word(8'h11);
        write_word(8'h22);
        cycle();
        chk1("ovr_set",  ifa.OVERRUN, 1'b1);
        chk1("ovr_full", ifa.SENDER_FULL_STATE, 1'b1);
        ifa.OVR_CLR = 1'b1;
        cycle();
        ifa.OVR_CLR = 1'b0;
        chk1("ovr_clr", ifa.OVERRUN, 1'b0);
        clear_obs();
        ifa.TE = 1'b1;
        wait_done(1, 60);
        chkv("ovr_kept", 32'(rx_a[7:0]), 32'h11);

        // Abort after the third SCLK rise.
        cycle();
        clear_obs();
        write_word(8'h5A);
        while (rises < 3 && ncyc < 60) cycle();
        ifa.TE = 1'b0;
        cycle();
        chk1("abort_sclk",  ifa.SCLK, 1'b0);
        chk1("abort_empty", ifa.SENDER_EMPTY_STATE, 1'b1);
        repeat (40) cycle();
        chkv("abort_no_done", dones, 0);
        ifa.TE = 1'b1;

        // Asynchronous reset in SHIFT_HI with a refilled holding register.
        cycle();
        clear_obs();
        write_word(8'h77);
        repeat (3) cycle();
        write_word(8'h99);
        while (!(ifa.SCLK && rises >= 2) && ncyc < 60) cycle();
        chk1("pre_rst_full", ifa.SENDER_FULL_STATE, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_rst_sclk",  ifa.SCLK, 1'b0);
        chk1("mid_rst_mosi",  ifa.MOSI, 1'b0);
        chk1("mid_rst_full",  ifa.SENDER_FULL_STATE, 1'b0);
        chk1("mid_rst_empty", ifa.SENDER_EMPTY_STATE, 1'b1);
        chk1("mid_rst_done",  ifa.TX_DONE, 1'b0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ifa.SENDER_WRITE = ($urandom_range(0, 5) == 0);
            ifa.BUFFER_DATA  = W'($urandom);
            ifa.TE           = ($urandom_range(0, 299) != 0);
            ifa.CS           = ($urandom_range(0, 299) == 0);
            ifa.OVR_CLR      = ($urandom_range(0, 19) == 0);
            cycle();
        end
        ifa.SENDER_WRITE = 1'b0;
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
